temporizador_bcd: RTL and testbench
===================================

TEMPORIZADOR_BCD -- requirements
Module: temporizador_bcd

Interface
REQ-001 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-002 Port list, one per line (name  direction  width  meaning), clock and reset first, SHALL be:
- clock  input  1  system clock; all state on rising edge
- clearn  input  1  asynchronous active-low reset
- d  input  4  BCD key digit from keypad encoder
- loadn  input  1  active-low load strobe from encoder; one low pulse per keypress
- pgt_1hz  input  1  1 Hz timebase from encoder; level signal, only its rising edge is used
- enable  input  1  count enable from control (1 = magnetron running)
- sec_ones  output  4  BCD seconds units
- sec_tens  output  4  BCD seconds tens
- min_ones  output  4  BCD minutes units
- min_tens  output  4  BCD minutes tens (only with TEMPORIZADOR_MIN_TENS_EN)
- zero  output  1  high when all digit registers are 0
- done  output  1  one-cycle pulse when countdown reaches zero

Function
REQ-003 The block SHALL register loadn and pgt_1hz once each (loadn_q, tick_q) and use only their edges: load event = loadn_q=1 and loadn=0; tick event = tick_q=0 and pgt_1hz=1.
REQ-004 A load event with enable=0 and d<=9 SHALL shift digits left in the same edge: min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=d; the old min_ones is discarded.
REQ-005 A load event with d>9 or with enable=1 SHALL be ignored; no digit changes.
REQ-006 Loaded sec_tens values 6..9 SHALL be accepted as-is (e.g. 1:75); countdown handles them per REQ-008.
REQ-007 A tick event with enable=1 and zero=0 SHALL decrement the time by one second, effective the clock edge on which the tick event is detected (one-cycle latency from the pgt_1hz rise).
REQ-008 Decrement rules:
- sec_ones>0 -> sec_ones-1.
- sec_ones=0 -> sec_ones=9 and borrow into sec_tens.
- sec_tens borrow with sec_tens>0 -> sec_tens-1.
- sec_tens borrow with sec_tens=0 -> sec_tens=5 and borrow into min_ones.
- min_ones borrow -> min_ones-1.
REQ-009 A tick event with enable=0, or with zero=1, SHALL leave all digits unchanged; the count never wraps below 0:00.
REQ-010 zero SHALL be combinational from the registered digits: 1 iff every implemented digit is 0.
REQ-011 done SHALL be a registered pulse, high for exactly one clock after a decrement that moves the count from 0:01 to 0:00; loading or reset to zero SHALL NOT raise done.
REQ-012 Load and decrement are mutually exclusive by enable; when both edges coincide, only the operation allowed by the current enable SHALL occur.
REQ-013 Toggling enable mid-count SHALL pause and resume the count without losing digits; an already-pending edge is judged by enable at that clock edge.

Reset
REQ-014 While clearn=0, all digits SHALL be 0, done=0, loadn_q=1 and tick_q=0; therefore zero=1.
REQ-015 Reset asserted mid-count or mid-entry SHALL abort the operation immediately; after release, the first edge is detected only on a fresh loadn fall or pgt_1hz rise.

Configuration
REQ-016 With macro TEMPORIZADOR_MIN_TENS_EN defined:
- min_tens port and register exist, so the shift chain is four digits (min_tens<=min_ones).
- min_ones borrow at 0 -> min_ones=9 and min_tens-1; maximum count is 99:59.
- zero includes min_tens.
REQ-017 Without TEMPORIZADOR_MIN_TENS_EN: the min_tens port is absent, the shift chain is three digits, and the maximum count is 9:59.

Verification
REQ-018 Reset, then keys 1,0,5 with enable=0 -> digits 1:05, zero=0.
REQ-019 From 1:05, enable=1, 6 pgt_1hz rises -> 0:59; each change occurs 1 clock after the pgt_1hz rise.
REQ-020 From 0:02, enable=1, 3 rises -> 0:01, then 0:00 with done high for exactly 1 cycle; the third rise leaves 0:00 and done=0.
REQ-021 Keys with d=12 and a key pressed while enable=1 -> digits unchanged.
REQ-022 clearn pulsed low mid-count at 0:37 -> all digits 0, zero=1, done=0; pgt_1hz held high through release -> no decrement.
REQ-023 With TEMPORIZADOR_MIN_TENS_EN, keys 1,0,0,0, enable=1, 1 rise -> 09:59.

Source files
------------

// File: rtl/temporizador_bcd.sv
`default_nettype none
// ============================================================================
//  Module      : temporizador_bcd
//  Description : BCD countdown timer (m:ss, or mm:ss with
//                TEMPORIZADOR_MIN_TENS_EN) for a microwave keypad/timebase.
//  Revision    : 1.0 - initial release
// ============================================================================
module temporizador_bcd (
   input  logic       clock,
   input  logic       clearn,
   input  logic [3:0] d,
   input  logic       loadn,
   input  logic       pgt_1hz,
   input  logic       enable,
   output logic [3:0] sec_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] min_ones,
`ifdef TEMPORIZADOR_MIN_TENS_EN
   output logic [3:0] min_tens,
`endif
   output logic       zero,
   output logic       done
);

   localparam logic [3:0] c_bcd_max   = 4'd9;
   localparam logic [3:0] c_tens_wrap = 4'd5;
   localparam logic [3:0] c_digit_0   = 4'd0;
   localparam logic [3:0] c_digit_1   = 4'd1;

   logic       r_loadn_q;
   logic       r_tick_q;
   logic [3:0] r_sec_ones;
   logic [3:0] r_sec_tens;
   logic [3:0] r_min_ones;
   logic       r_done;

   logic       w_load_ev;
   logic       w_tick_ev;
   logic       w_do_load;
   logic       w_do_dec;
   logic       w_zero;
   logic       w_dec_is_zero;
   logic [3:0] w_dec_sec_ones;
   logic [3:0] w_dec_sec_tens;
   logic [3:0] w_dec_min_ones;

`ifdef TEMPORIZADOR_MIN_TENS_EN
   logic [3:0] r_min_tens;
   logic [3:0] w_dec_min_tens;
`endif

   assign w_load_ev = r_loadn_q & ~loadn;
   assign w_tick_ev = ~r_tick_q & pgt_1hz;

   // Enable arbitrates: keypad entry only while stopped, countdown only while running.
   assign w_do_load = w_load_ev & ~enable & (d <= c_bcd_max);
   assign w_do_dec  = w_tick_ev &  enable & ~w_zero;

`ifdef TEMPORIZADOR_MIN_TENS_EN
   assign w_zero = (r_sec_ones == c_digit_0) && (r_sec_tens == c_digit_0) &&
                   (r_min_ones == c_digit_0) && (r_min_tens == c_digit_0);
   assign w_dec_is_zero = (w_dec_sec_ones == c_digit_0) && (w_dec_sec_tens == c_digit_0) &&
                          (w_dec_min_ones == c_digit_0) && (w_dec_min_tens == c_digit_0);
`else
   assign w_zero = (r_sec_ones == c_digit_0) && (r_sec_tens == c_digit_0) &&
                   (r_min_ones == c_digit_0);
   assign w_dec_is_zero = (w_dec_sec_ones == c_digit_0) && (w_dec_sec_tens == c_digit_0) &&
                          (w_dec_min_ones == c_digit_0);
`endif

   // One-second borrow chain; only meaningful when the count is non-zero.
   always_comb begin
      w_dec_sec_ones = r_sec_ones;
      w_dec_sec_tens = r_sec_tens;
      w_dec_min_ones = r_min_ones;
`ifdef TEMPORIZADOR_MIN_TENS_EN
      w_dec_min_tens = r_min_tens;
`endif
      if (r_sec_ones != c_digit_0) begin
         w_dec_sec_ones = r_sec_ones - c_digit_1;
      end else begin
         w_dec_sec_ones = c_bcd_max;
         if (r_sec_tens != c_digit_0) begin
            w_dec_sec_tens = r_sec_tens - c_digit_1;
         end else begin
            w_dec_sec_tens = c_tens_wrap;
`ifdef TEMPORIZADOR_MIN_TENS_EN
            if (r_min_ones != c_digit_0) begin
               w_dec_min_ones = r_min_ones - c_digit_1;
            end else begin
               w_dec_min_ones = c_bcd_max;
               w_dec_min_tens = r_min_tens - c_digit_1;
            end
`else
            w_dec_min_ones = r_min_ones - c_digit_1;
`endif
         end
      end
   end

   always_ff @(posedge clock or negedge clearn) begin
      if (!clearn) begin
         r_loadn_q  <= 1'b1;
         r_tick_q   <= 1'b0;
         r_sec_ones <= c_digit_0;
         r_sec_tens <= c_digit_0;
         r_min_ones <= c_digit_0;
         r_done     <= 1'b0;
      end else begin
         r_loadn_q <= loadn;
         r_tick_q  <= pgt_1hz;
         r_done    <= w_do_dec & w_dec_is_zero;
         if (w_do_load) begin
            r_min_ones <= r_sec_tens;
            r_sec_tens <= r_sec_ones;
            r_sec_ones <= d;
         end else if (w_do_dec) begin
            r_min_ones <= w_dec_min_ones;
            r_sec_tens <= w_dec_sec_tens;
            r_sec_ones <= w_dec_sec_ones;
         end
      end
   end

`ifdef TEMPORIZADOR_MIN_TENS_EN
   always_ff @(posedge clock or negedge clearn) begin
      if (!clearn) begin
         r_min_tens <= c_digit_0;
      end else if (w_do_load) begin
         r_min_tens <= r_min_ones;
      end else if (w_do_dec) begin
         r_min_tens <= w_dec_min_tens;
      end
   end

   assign min_tens = r_min_tens;
`endif

   assign sec_ones = r_sec_ones;
   assign sec_tens = r_sec_tens;
   assign min_ones = r_min_ones;
   assign zero     = w_zero;
   assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_temporizador_bcd.sv
`default_nettype none
// ============================================================================
//  Module      : tb_temporizador_bcd
//  Description : Vector-table and scoreboard bench for temporizador_bcd.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_temporizador_bcd;

   logic       clock = 1'b0;
   logic       clearn;
   logic [3:0] d;
   logic       loadn;
   logic       pgt_1hz;
   logic       enable;
   logic [3:0] sec_ones;
   logic [3:0] sec_tens;
   logic [3:0] min_ones;
`ifdef TEMPORIZADOR_MIN_TENS_EN
   logic [3:0] min_tens;
`endif
   logic       zero;
   logic       done;

   temporizador_bcd dut (
      .clock    (clock),
      .clearn   (clearn),
      .d        (d),
      .loadn    (loadn),
      .pgt_1hz  (pgt_1hz),
      .enable   (enable),
      .sec_ones (sec_ones),
      .sec_tens (sec_tens),
      .min_ones (min_ones),
`ifdef TEMPORIZADOR_MIN_TENS_EN
      .min_tens (min_tens),
`endif
      .zero     (zero),
      .done     (done)
   );

   always #5 clock = ~clock;

   // {min_tens, min_ones, sec_tens, sec_ones, zero, done}
   typedef logic [17:0] obs_t;

   typedef struct {
      logic       ln;
      logic       tk;
      logic       en;
      logic [3:0] dv;
      obs_t       exp;
   } vec_t;

   vec_t tbl[$];
   obs_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic obs_t mk(input logic [3:0] mt, input logic [3:0] mo,
                               input logic [3:0] st, input logic [3:0] so,
                               input logic z, input logic dn);
      return {mt, mo, st, so, z, dn};
   endfunction

   function automatic obs_t observe();
`ifdef TEMPORIZADOR_MIN_TENS_EN
      return {min_tens, min_ones, sec_tens, sec_ones, zero, done};
`else
      return {4'd0, min_ones, sec_tens, sec_ones, zero, done};
`endif
   endfunction

   task automatic check(input string name, input obs_t act, input obs_t exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h%h:%h%h zero=%b done=%b, want %h%h:%h%h zero=%b done=%b",
                  name, act[17:14], act[13:10], act[9:6], act[5:2], act[1], act[0],
                  exp[17:14], exp[13:10], exp[9:6], exp[5:2], exp[1], exp[0]);
      end
   endtask

   // Drive one cycle of inputs at a falling edge, score the result at the next one.
   task automatic step(input string name, input logic ln, input logic tk,
                       input logic en, input logic [3:0] dv, input obs_t e);
      obs_t want;
      loadn   = ln;
      pgt_1hz = tk;
      enable  = en;
      d       = dv;
      exp_q.push_back(e);
      @(negedge clock);
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: scoreboard empty", name);
      end else begin
         want = exp_q.pop_front();
         check(name, observe(), want);
      end
   endtask

   task automatic add(input logic ln, input logic tk, input logic en, input logic [3:0] dv,
                      input logic [3:0] mo, input logic [3:0] st, input logic [3:0] so,
                      input logic z, input logic dn);
      vec_t v;
      v.ln  = ln;
      v.tk  = tk;
      v.en  = en;
      v.dv  = dv;
      v.exp = mk(4'd0, mo, st, so, z, dn);
      tbl.push_back(v);
   endtask

   initial begin
`ifndef TEMPORIZADOR_MIN_TENS_EN
      // keys 1,0,5 while stopped
      add(0,0,0,1,  0,0,1, 0,0);  add(1,0,0,1,  0,0,1, 0,0);
      add(0,0,0,0,  0,1,0, 0,0);  add(1,0,0,0,  0,1,0, 0,0);
      add(0,0,0,5,  1,0,5, 0,0);  add(1,0,0,5,  1,0,5, 0,0);
      // non-BCD key, then a key while running
      add(0,0,0,12, 1,0,5, 0,0);  add(1,0,0,12, 1,0,5, 0,0);
      add(0,0,1,3,  1,0,5, 0,0);  add(1,0,1,3,  1,0,5, 0,0);
      // six ticks, first one held high for an extra cycle
      add(1,1,1,0,  1,0,4, 0,0);  add(1,1,1,0,  1,0,4, 0,0);  add(1,0,1,0, 1,0,4, 0,0);
      add(1,1,1,0,  1,0,3, 0,0);  add(1,0,1,0,  1,0,3, 0,0);
      add(1,1,1,0,  1,0,2, 0,0);  add(1,0,1,0,  1,0,2, 0,0);
      add(1,1,1,0,  1,0,1, 0,0);  add(1,0,1,0,  1,0,1, 0,0);
      add(1,1,1,0,  1,0,0, 0,0);  add(1,0,1,0,  1,0,0, 0,0);
      add(1,1,1,0,  0,5,9, 0,0);  add(1,0,1,0,  0,5,9, 0,0);
      // pause and resume
      add(1,0,0,0,  0,5,9, 0,0);  add(1,1,0,0,  0,5,9, 0,0);  add(1,0,0,0, 0,5,9, 0,0);
      add(1,1,1,0,  0,5,8, 0,0);  add(1,0,1,0,  0,5,8, 0,0);
      // load and tick edges together while running: decrement only
      add(0,1,1,4,  0,5,7, 0,0);  add(1,0,1,4,  0,5,7, 0,0);
      // keys 0,0,2 shift through 5:70, 7:00 to 0:02
      add(0,0,0,0,  5,7,0, 0,0);  add(1,0,0,0,  5,7,0, 0,0);
      add(0,0,0,0,  7,0,0, 0,0);  add(1,0,0,0,  7,0,0, 0,0);
      add(0,0,0,2,  0,0,2, 0,0);  add(1,0,0,2,  0,0,2, 0,0);
      // run out: done only on the 0:01 -> 0:00 step
      add(1,1,1,0,  0,0,1, 0,0);  add(1,0,1,0,  0,0,1, 0,0);
      add(1,1,1,0,  0,0,0, 1,1);  add(1,0,1,0,  0,0,0, 1,0);
      add(1,1,1,0,  0,0,0, 1,0);  add(1,0,1,0,  0,0,0, 1,0);
      // both edges together while stopped: load only
      add(0,1,0,4,  0,0,4, 0,0);  add(1,0,0,4,  0,0,4, 0,0);
      // 1:75 accepted and counted down
      add(0,0,0,1,  0,4,1, 0,0);  add(1,0,0,1,  0,4,1, 0,0);
      add(0,0,0,7,  4,1,7, 0,0);  add(1,0,0,7,  4,1,7, 0,0);
      add(0,0,0,5,  1,7,5, 0,0);  add(1,0,0,5,  1,7,5, 0,0);
      add(1,1,1,0,  1,7,4, 0,0);  add(1,0,1,0,  1,7,4, 0,0);
      // 1:70 borrows to 1:69
      add(0,0,0,1,  7,4,1, 0,0);  add(1,0,0,1,  7,4,1, 0,0);
      add(0,0,0,7,  4,1,7, 0,0);  add(1,0,0,7,  4,1,7, 0,0);
      add(0,0,0,0,  1,7,0, 0,0);  add(1,0,0,0,  1,7,0, 0,0);
      add(1,1,1,0,  1,6,9, 0,0);  add(1,0,1,0,  1,6,9, 0,0);
      // keys 0,3,7 to set up 0:37
      add(0,0,0,0,  6,9,0, 0,0);  add(1,0,0,0,  6,9,0, 0,0);
      add(0,0,0,3,  9,0,3, 0,0);  add(1,0,0,3,  9,0,3, 0,0);
      add(0,0,0,7,  0,3,7, 0,0);  add(1,0,0,7,  0,3,7, 0,0);
`endif

      clearn  = 1'b0;
      loadn   = 1'b1;
      pgt_1hz = 1'b0;
      enable  = 1'b0;
      d       = 4'd0;
      @(negedge clock);
      @(negedge clock);
      check("reset_hold", observe(), mk(0,0,0,0,1,0));
      clearn = 1'b1;
      @(negedge clock);
      check("reset_release", observe(), mk(0,0,0,0,1,0));

`ifdef TEMPORIZADOR_MIN_TENS_EN
      step("mt_key1", 0,0,0,4'd1, mk(0,0,0,1,0,0));
      step("mt_rel1", 1,0,0,4'd1, mk(0,0,0,1,0,0));
      step("mt_key0a",0,0,0,4'd0, mk(0,0,1,0,0,0));
      step("mt_rel2", 1,0,0,4'd0, mk(0,0,1,0,0,0));
      step("mt_key0b",0,0,0,4'd0, mk(0,1,0,0,0,0));
      step("mt_rel3", 1,0,0,4'd0, mk(0,1,0,0,0,0));
      step("mt_key0c",0,0,0,4'd0, mk(1,0,0,0,0,0));
      step("mt_rel4", 1,0,0,4'd0, mk(1,0,0,0,0,0));
      step("mt_tick", 1,1,1,4'd0, mk(0,9,5,9,0,0));
      step("mt_low",  1,0,1,4'd0, mk(0,9,5,9,0,0));
      step("mt_tick2",1,1,1,4'd0, mk(0,9,5,8,0,0));
      step("mt_low2", 1,0,0,4'd0, mk(0,9,5,8,0,0));
`else
      for (int i = 0; i < tbl.size(); i++)
         step($sformatf("vec%0d", i), tbl[i].ln, tbl[i].tk, tbl[i].en, tbl[i].dv, tbl[i].exp);

      // Asynchronous reset at 0:37 with a tick rise pending, tick held high through release
      loadn   = 1'b1;
      enable  = 1'b1;
      pgt_1hz = 1'b1;
      #2 clearn = 1'b0;
      #1 check("async_clear", observe(), mk(0,0,0,0,1,0));
      @(negedge clock);
      check("clear_held", observe(), mk(0,0,0,0,1,0));
      clearn = 1'b1;
      step("post_clear_a", 1,1,1,4'd0, mk(0,0,0,0,1,0));
      step("post_clear_b", 1,1,1,4'd0, mk(0,0,0,0,1,0));
      // entry after release: first fresh loadn fall is taken
      step("post_key",     0,1,0,4'd2, mk(0,0,0,2,0,0));
      step("post_rel",     1,0,0,4'd2, mk(0,0,0,2,0,0));
      step("post_tick",    1,1,1,4'd2, mk(0,0,0,1,0,0));
      step("post_low",     1,0,1,4'd2, mk(0,0,0,1,0,0));
`endif

      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL scoreboard_drain: %0d left, want 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
